// File: rtl/grf_writeback_ctrl_pkg.sv
// Shared types for the GRF write-side controller.
package grf_writeback_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_writeback_ctrl_wb_fifo.sv
// Source-B writeback queue with per-entry valids,
// address kill, and busy lookup on two query ports.
module wb_fifo
  import grf_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   kill_en,
  input  logic [REG_W-1:0]       kill_addr,
  input  logic [REG_W-1:0]       q_addr1,
  input  logic [REG_W-1:0]       q_addr2,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   any_valid,
  output logic                   busy1,
  output logic                   busy2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].valid && mem_q[i].addr == kill_addr)
          mem_d[i].valid = 1'b0;
      end
    end
    if (pop) begin
      mem_d[rd_q].valid = 1'b0;
      rd_d = rd_q + PW'(1);
    end
    // push lands in a free slot, so it is never hit by the kill
    if (push) begin
      mem_d[wr_q] = push_entry;
      wr_d = wr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    busy1     = 1'b0;
    busy2     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid) begin
        any_valid = 1'b1;
        if (q_addr1 != '0 && mem_q[i].addr == q_addr1)
          busy1 = 1'b1;
        if (q_addr2 != '0 && mem_q[i].addr == q_addr2)
          busy2 = 1'b1;
      end
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/grf_writeback_ctrl.sv
// Merges pipeline writeback (A) and queued slow results (B)
// onto the single GRF write port, with starvation guard.
module grf_writeback_ctrl
  import grf_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] a_pc,
  output logic              a_stall,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] b_pc,
  input  logic [REG_W-1:0]  query_addr1,
  input  logic [REG_W-1:0]  query_addr2,
  output logic              query_busy1,
  output logic              query_busy2,
  output logic              WriteEnable,
  output logic [REG_W-1:0]  WriteAddress,
  output logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] WritePC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic [CW-1:0]     count;
  logic              any_valid;
  logic              a_sel, pop, push, emit_b;
  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pc_q, pc_d;

  assign b_ready = count < CW'(DEPTH);
  assign a_stall = (starve_q == LIMIT) && any_valid;
  assign a_sel   = a_valid && !a_stall && (a_addr != '0);
  assign pop     = !a_sel && (count != '0);
  assign emit_b  = pop && head.valid;
  assign push    = b_valid && b_ready && (b_addr != '0);

  assign push_entry = '{valid: 1'b1, addr: b_addr,
                        data: b_data, pc: b_pc};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (a_sel),
    .kill_addr  (a_addr),
    .q_addr1    (query_addr1),
    .q_addr2    (query_addr2),
    .head       (head),
    .count      (count),
    .any_valid  (any_valid),
    .busy1      (query_busy1),
    .busy2      (query_busy2)
  );

  always_comb begin
    starve_d = starve_q;
    if (pop || !any_valid)
      starve_d = '0;
    else if (starve_q != LIMIT)
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    pc_d   = pc_q;
    unique case (1'b1)
      a_sel: begin
        we_d   = 1'b1;
        addr_d = a_addr;
        data_d = a_data;
        pc_d   = a_pc;
      end
      emit_b: begin
        we_d   = 1'b1;
        addr_d = head.addr;
        data_d = head.data;
        pc_d   = head.pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pc_q     <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
    end
  end

  assign WriteEnable  = we_q;
  assign WriteAddress = addr_q;
  assign WriteData    = data_q;
  assign WritePC      = pc_q;

endmodule

// File: tb/tb_grf_writeback_ctrl.sv
// Directed bench for grf_writeback_ctrl (DEPTH=4, STARVE_LIMIT=8).
module tb_grf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data, a_pc;
  logic        a_stall;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data, b_pc;
  logic [4:0]  qa1, qa2;
  logic        qb1, qb2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd, wpc;

  int n_assert = 0;
  int n_fail   = 0;

  grf_writeback_ctrl #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_pc         (a_pc),
    .a_stall      (a_stall),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_pc         (b_pc),
    .query_addr1  (qa1),
    .query_addr2  (qa2),
    .query_busy1  (qb1),
    .query_busy2  (qb2),
    .WriteEnable  (we),
    .WriteAddress (wa),
    .WriteData    (wd),
    .WritePC      (wpc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0; a_pc = 0;
    b_valid = 1; b_addr = 5; b_data = 32'h55; b_pc = 32'h100;
    qa1 = 5; qa2 = 0;

    // reset with b_valid held high
    tick(); tick();
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_wa", {27'b0, wa}, 0);
    chk("rst_wd", wd, 0);
    chk("rst_wpc", wpc, 0);
    chk("rst_bready", {31'b0, b_ready}, 1);
    chk("rst_busy", {31'b0, qb1}, 0);

    // first B write: handshake, then 2 cycles later on the port
    Reset = 1'b0;
    tick();
    b_valid = 0;
    chk("b1_busy", {31'b0, qb1}, 1);
    chk("b1_we0", {31'b0, we}, 0);
    tick();
    chk("b1_we", {31'b0, we}, 1);
    chk("b1_wa", {27'b0, wa}, 5);
    chk("b1_wd", wd, 32'h55);
    chk("b1_wpc", wpc, 32'h100);
    chk("b1_busy_off", {31'b0, qb1}, 0);
    tick();
    chk("b1_one_cycle", {31'b0, we}, 0);
    chk("b1_hold_wa", {27'b0, wa}, 5);

    // priority: A beats queued B
    b_valid = 1; b_addr = 4; b_data = 32'h22; b_pc = 32'h204;
    tick();
    b_valid = 0;
    a_valid = 1; a_addr = 3; a_data = 32'h11; a_pc = 32'h200;
    tick();
    a_valid = 0;
    chk("pri_a_we", {31'b0, we}, 1);
    chk("pri_a_wa", {27'b0, wa}, 3);
    chk("pri_a_wd", wd, 32'h11);
    chk("pri_a_wpc", wpc, 32'h200);
    tick();
    chk("pri_b_we", {31'b0, we}, 1);
    chk("pri_b_wa", {27'b0, wa}, 4);
    chk("pri_b_wd", wd, 32'h22);
    chk("pri_b_wpc", wpc, 32'h204);
    tick();
    chk("pri_idle", {31'b0, we}, 0);

    // full FIFO with A held busy on r1
    a_valid = 1; a_addr = 1; a_data = 32'h1; a_pc = 32'h300;
    b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_addr = 5'(8 + i); b_data = 32'(8 + i); b_pc = 32'h400;
      tick();
    end
    chk("full_bready", {31'b0, b_ready}, 0);
    b_addr = 12; b_data = 32'hC;
    qa1 = 12; qa2 = 11;
    tick();
    chk("full_no_accept", {31'b0, qb1}, 0);
    chk("full_busy11", {31'b0, qb2}, 1);
    chk("full_bready2", {31'b0, b_ready}, 0);
    chk("full_nostall", {31'b0, a_stall}, 0);
    a_valid = 0;
    tick();
    chk("full_pop8", {27'b0, wa}, 8);
    chk("full_bready_up", {31'b0, b_ready}, 1);
    chk("full_still_out", {31'b0, qb1}, 0);
    tick();
    b_valid = 0;
    chk("full_pop9", {27'b0, wa}, 9);
    chk("full_busy12", {31'b0, qb1}, 1);
    tick();
    chk("full_pop10", {27'b0, wa}, 10);
    tick();
    chk("full_pop11", {27'b0, wa}, 11);
    tick();
    chk("full_pop12_wa", {27'b0, wa}, 12);
    chk("full_pop12_wd", wd, 32'hC);
    tick();
    chk("full_drained", {31'b0, we}, 0);

    // stale kill: A to r7 supersedes queued B to r7
    qa1 = 7;
    b_valid = 1; b_addr = 7; b_data = 32'hAAAA; b_pc = 32'h500;
    tick();
    b_valid = 0;
    chk("kill_busy_on", {31'b0, qb1}, 1);
    a_valid = 1; a_addr = 7; a_data = 32'hBBBB; a_pc = 32'h504;
    tick();
    a_valid = 0;
    chk("kill_a_wd", wd, 32'hBBBB);
    chk("kill_busy_off", {31'b0, qb1}, 0);
    tick();
    chk("kill_silent_we", {31'b0, we}, 0);
    chk("kill_hold_wd", wd, 32'hBBBB);
    tick();
    chk("kill_idle", {31'b0, we}, 0);

    // starvation: A every cycle, one B entry waiting
    a_valid = 1; a_addr = 2; a_data = 32'h2; a_pc = 32'h600;
    b_valid = 1; b_addr = 9; b_data = 32'h99; b_pc = 32'h604;
    tick();
    b_valid = 0;
    chk("stv_start", {31'b0, a_stall}, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("stv_wait%0d", i), {31'b0, a_stall}, 0);
    end
    tick();
    chk("stv_stall", {31'b0, a_stall}, 1);
    chk("stv_a_out", {27'b0, wa}, 2);
    tick();
    chk("stv_b_wa", {27'b0, wa}, 9);
    chk("stv_b_wd", wd, 32'h99);
    chk("stv_release", {31'b0, a_stall}, 0);
    tick();
    chk("stv_a_again", {27'b0, wa}, 2);
    a_valid = 0;
    tick();

    // writes to $0 from both sources
    a_valid = 1; a_addr = 0; a_data = 32'hDEAD;
    b_valid = 1; b_addr = 0; b_data = 32'hBEEF;
    qa1 = 0;
    chk("z_bready", {31'b0, b_ready}, 1);
    tick();
    a_valid = 0; b_valid = 0;
    chk("z_we1", {31'b0, we}, 0);
    chk("z_busy", {31'b0, qb1}, 0);
    tick();
    chk("z_we2", {31'b0, we}, 0);
    chk("z_hold_wd", wd, 32'h2);

    // reset mid-operation discards queued B
    qa1 = 6;
    b_valid = 1; b_addr = 6; b_data = 32'h66;
    tick();
    b_valid = 0;
    a_valid = 1; a_addr = 1; a_data = 32'h77;
    tick();
    chk("mr_busy_pre", {31'b0, qb1}, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; a_valid = 0;
    chk("mr_wd_clr", wd, 0);
    chk("mr_busy", {31'b0, qb1}, 0);
    tick();
    chk("mr_we", {31'b0, we}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_writeback_ctrl.md
Name: grf_writeback_ctrl

Overview:
Write-side controller for the general register file. It merges two result producers into the GRF's single write port:
- Source A: the in-order pipeline writeback, single cycle, highest priority.
- Source B: a slow producer such as the mult/div unit or a multi-cycle load, using a valid/ready handshake and buffered in a small FIFO.

It drives the GRF write port from registered outputs, reports per-register busy status for hazard stalls, and stalls source A when the FIFO starves.

Parameters:
DEPTH, 4, number of FIFO entries for source B (power of 2, minimum 2).
STARVE_LIMIT, 8, consecutive cycles with FIFO non-empty and not drained before a_stall is forced.

Ports:
clk  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
a_valid  in  1  source A write request this cycle.
a_addr  in  5  source A destination register.
a_data  in  32  source A write data.
a_pc  in  32  source A instruction PC.
a_stall  out  1  combinational; when high, source A must hold and a_valid is ignored this cycle.
b_valid  in  1  source B offers a write.
b_ready  out  1  source B accepted when b_valid && b_ready.
b_addr  in  5  source B destination register.
b_data  in  32  source B write data.
b_pc  in  32  source B instruction PC.
query_addr1  in  5  register read by the decode stage, port 1.
query_addr2  in  5  register read by the decode stage, port 2.
query_busy1  out  1  combinational; query_addr1 has a write queued in the FIFO.
query_busy2  out  1  same for query_addr2.
WriteEnable  out  1  GRF write enable (registered).
WriteAddress  out  5  GRF write address (registered).
WriteData  out  32  GRF write data (registered).
WritePC  out  32  PC of the write in flight, for the trace display (registered).

Behaviour:
- Reset (synchronous, takes precedence over everything): WriteEnable=0, WriteAddress=0, WriteData=0, WritePC=0; FIFO emptied (all entry valids 0, pointers 0, count 0); starve counter 0. Reset mid-operation discards all queued B entries.
- Outputs update one cycle after selection: a request selected in cycle N appears on Write* in cycle N+1 and lasts exactly one cycle.
- Selection, each cycle, in priority order:
  1. a_valid && !a_stall && a_addr!=0: emit A.
  2. Otherwise, FIFO holds a valid head: pop the head and emit it.
  3. Otherwise: WriteEnable=0, other Write* outputs hold their previous values.
- Register $0: an A write to $0 is ignored. A B handshake to $0 completes but is not enqueued.
- b_ready = (count < DEPTH), computed from registered count only. A pop in the same cycle does not raise b_ready.
- Push and pop in the same cycle are legal; count is unchanged.
- Stale kill: when A is emitted to register X, every valid FIFO entry with addr X is invalidated in the same cycle, because A is architecturally newer. A B entry pushed in that same cycle to X is not killed.
- Invalid entries reaching the head are popped silently without a write: WriteEnable=0 that cycle, and the pop counts as a drain.
- Busy: query_busyN = (query_addrN != 0) && some valid FIFO entry has addr == query_addrN. The entry currently on the output register is not counted; the GRF write lands that cycle.
- Starve counter:
  - increments when the FIFO holds at least one valid entry and no pop occurs;
  - clears on any pop or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- a_stall = (starve counter == STARVE_LIMIT) && FIFO holds a valid entry. This guarantees at least one drain every STARVE_LIMIT+1 cycles.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package: the writeback entry typedef {valid, addr[4:0], data[31:0], pc[31:0]}, the register-number width constant (5), and the data width constant (32).
- One sub-module: wb_fifo. It holds the storage, per-entry valid bits, the kill-by-address input, pop-skips-invalid handling, and the busy CAM outputs.
- Arbitration, starve counter and output registers stay in the top.

Test Plan:
- Reset: assert Reset for 2 cycles with b_valid=1 -> all Write* 0, b_ready=1, query_busy1=0. Deassert -> the first B write appears 2 cycles after its handshake.
- Priority: same cycle a_valid (addr 3, data 0x11) and B queued (addr 4, data 0x22) -> WriteEnable in N+1 with addr 3/0x11, then in N+2 with addr 4/0x22.
- Full FIFO: DEPTH=4, push 4 B entries with a_valid held high -> b_ready=0 after the 4th push, and a 5th b_valid is not accepted until a pop.
- Stale kill: B queued to reg 7 (0xAAAA), then A writes reg 7 (0xBBBB) -> only 0xBBBB reaches the GRF, and query_busy for 7 drops the cycle after the kill.
- Starvation: a_valid=1 every cycle with one B entry queued, STARVE_LIMIT=8 -> a_stall=1 on the 9th cycle, B drains, and a_stall returns to 0.
- $0 writes: A to $0 and B to $0 -> WriteEnable never asserts, and the B handshake still completes.
